// File: rtl/ss_call_ret_if.sv
// Commit-side and stack-side signals of the call/return shadow-stack monitor.
// The monitor uses the slave modport; the commit/stack environment uses master.
interface ss_call_ret_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
);
  logic             i_commit_valid;
  logic             o_commit_ready;
  logic             i_is_call;
  logic             i_is_ret;
  logic             i_is_compressed;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_ret_target;
  logic             o_push;
  logic [XLEN-1:0]  o_push_data;
  logic             i_full;
  logic             o_pop;
  logic [XLEN-1:0]  i_pop_data;
  logic             i_empty;
  logic             i_clear_viol;
  logic             o_violation;
  logic             o_viol_pulse;
  logic [XLEN-1:0]  o_viol_expected;
  logic [XLEN-1:0]  o_viol_actual;
  logic             o_overflow;
  logic             o_underflow;
  logic [CNT_W-1:0] o_call_cnt;
  logic [CNT_W-1:0] o_ret_cnt;

  modport master (
    output i_commit_valid, i_is_call, i_is_ret, i_is_compressed, i_pc, i_ret_target,
           i_full, i_pop_data, i_empty, i_clear_viol,
    input  o_commit_ready, o_push, o_push_data, o_pop, o_violation, o_viol_pulse,
           o_viol_expected, o_viol_actual, o_overflow, o_underflow, o_call_cnt, o_ret_cnt
  );

  modport slave (
    input  i_commit_valid, i_is_call, i_is_ret, i_is_compressed, i_pc, i_ret_target,
           i_full, i_pop_data, i_empty, i_clear_viol,
    output o_commit_ready, o_push, o_push_data, o_pop, o_violation, o_viol_pulse,
           o_viol_expected, o_viol_actual, o_overflow, o_underflow, o_call_cnt, o_ret_cnt
  );
endinterface

// File: rtl/ss_call_ret_monitor.sv
// Commit-side shadow-stack monitor: pushes return addresses on calls, pops and
// checks them on returns, and records sticky violation / overflow / underflow status.
module ss_call_ret_monitor #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned UNDERFLOW_V = 1
) (
  input logic          clk,
  input logic          rstn,
  ss_call_ret_if.slave bus
);
  localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, CMP} state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              cmpr_q, cmpr_d;
  logic              defer_q, defer_d;

  logic              accept;
  logic              push_c, pop_c;
  logic [XLEN-1:0]   push_addr;
  logic              viol_ev, set_ovf, set_udf;
  logic [XLEN-1:0]   ev_exp, ev_act;
  logic              call_acc, ret_acc;

  assign accept              = bus.i_commit_valid && (state_q == IDLE);
  assign bus.o_commit_ready  = (state_q == IDLE);
  assign bus.o_push          = push_c;
  assign bus.o_pop           = pop_c;
  assign bus.o_push_data     = push_addr;

  // Next state, stack strobes and per-cycle status events.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tgt_d     = tgt_q;
    pc_d      = pc_q;
    cmpr_d    = cmpr_q;
    defer_d   = defer_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    push_addr = '0;
    viol_ev   = 1'b0;
    ev_exp    = '0;
    ev_act    = '0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    call_acc  = 1'b0;
    ret_acc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          call_acc = bus.i_is_call;
          ret_acc  = bus.i_is_ret;
          if (bus.i_is_ret && !bus.i_empty) begin
            // A call on the same instruction is deferred until the compare cycle.
            pop_c   = 1'b1;
            tgt_d   = bus.i_ret_target;
            pc_d    = bus.i_pc;
            cmpr_d  = bus.i_is_compressed;
            defer_d = bus.i_is_call;
            wcnt_d  = WCNT_W'(RD_LAT - 1);
            state_d = (RD_LAT > 1) ? WAIT : CMP;
          end else begin
            if (bus.i_is_ret) begin
              set_udf = 1'b1;
              if (UNDERFLOW_V != 0) begin
                viol_ev = 1'b1;
                ev_act  = bus.i_ret_target;
              end
            end
            if (bus.i_is_call) begin
              if (bus.i_full) begin
                set_ovf = 1'b1;
              end else begin
                push_c    = 1'b1;
                push_addr = bus.i_pc + (bus.i_is_compressed ? XLEN'(2) : XLEN'(4));
              end
            end
          end
        end
      end

      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) state_d = CMP;
      end

      CMP: begin
        state_d = IDLE;
        defer_d = 1'b0;
        if (bus.i_pop_data != tgt_q) begin
          viol_ev = 1'b1;
          ev_exp  = bus.i_pop_data;
          ev_act  = tgt_q;
        end
        if (defer_q) begin
          if (bus.i_full) begin
            set_ovf = 1'b1;
          end else begin
            push_c    = 1'b1;
            push_addr = pc_q + (cmpr_q ? XLEN'(2) : XLEN'(4));
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, pending-return context and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q             <= IDLE;
      wcnt_q              <= '0;
      tgt_q               <= '0;
      pc_q                <= '0;
      cmpr_q              <= 1'b0;
      defer_q             <= 1'b0;
      bus.o_violation     <= 1'b0;
      bus.o_viol_pulse    <= 1'b0;
      bus.o_viol_expected <= '0;
      bus.o_viol_actual   <= '0;
      bus.o_overflow      <= 1'b0;
      bus.o_underflow     <= 1'b0;
      bus.o_call_cnt      <= '0;
      bus.o_ret_cnt       <= '0;
    end else begin
      state_q          <= state_d;
      wcnt_q           <= wcnt_d;
      tgt_q            <= tgt_d;
      pc_q             <= pc_d;
      cmpr_q           <= cmpr_d;
      defer_q          <= defer_d;
      bus.o_viol_pulse <= viol_ev;
      // First violation is kept; a clear in the same cycle lets the new one in.
      if (viol_ev && (!bus.o_violation || bus.i_clear_viol)) begin
        bus.o_viol_expected <= ev_exp;
        bus.o_viol_actual   <= ev_act;
      end
      bus.o_violation <= viol_ev || (bus.o_violation && !bus.i_clear_viol);
      bus.o_overflow  <= set_ovf || (bus.o_overflow  && !bus.i_clear_viol);
      bus.o_underflow <= set_udf || (bus.o_underflow && !bus.i_clear_viol);
      if (call_acc && (bus.o_call_cnt != CNT_MAX)) bus.o_call_cnt <= bus.o_call_cnt + CNT_W'(1);
      if (ret_acc  && (bus.o_ret_cnt  != CNT_MAX)) bus.o_ret_cnt  <= bus.o_ret_cnt  + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ss_call_ret_monitor.sv
// Bench for ss_call_ret_monitor: directed scenarios on an RD_LAT=1 instance, then a
// reset-in-WAIT case and randomized traffic on an RD_LAT=3, 2-bit-counter instance.
module tb_ss_call_ret_monitor;
  localparam int unsigned XLEN  = 64;
  localparam int          L3    = 3;
  localparam int          CMAX3 = 3;

  logic clk = 1'b0;
  logic rstn1, rstn3;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ss_call_ret_if #(.XLEN(XLEN), .CNT_W(32)) b1 ();
  ss_call_ret_if #(.XLEN(XLEN), .CNT_W(2))  b3 ();

  ss_call_ret_monitor #(.XLEN(XLEN), .RD_LAT(1), .CNT_W(32), .UNDERFLOW_V(1)) dut1 (
    .clk(clk), .rstn(rstn1), .bus(b1)
  );
  ss_call_ret_monitor #(.XLEN(XLEN), .RD_LAT(3), .CNT_W(2), .UNDERFLOW_V(1)) dut3 (
    .clk(clk), .rstn(rstn3), .bus(b3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv1(input logic v, input logic ca, input logic re, input logic cp,
                      input logic [63:0] pc, input logic [63:0] tg);
    b1.i_commit_valid  = v;
    b1.i_is_call       = ca;
    b1.i_is_ret        = re;
    b1.i_is_compressed = cp;
    b1.i_pc            = pc;
    b1.i_ret_target    = tg;
  endtask

  task automatic drv3(input logic v, input logic ca, input logic re, input logic cp,
                      input logic [63:0] pc, input logic [63:0] tg);
    b3.i_commit_valid  = v;
    b3.i_is_call       = ca;
    b3.i_is_ret        = re;
    b3.i_is_compressed = cp;
    b3.i_pc            = pc;
    b3.i_ret_target    = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomized phase (transaction level).
  int          m_busy;
  logic [63:0] m_tgt, m_pc, m_exp, m_act;
  logic        m_c, m_call, m_viol, m_ovf, m_udf, m_pulse;
  int          m_ccnt, m_rcnt;

  initial begin
    logic        v, ca, re, cp, fu, em, cl;
    logic [63:0] pc, tg, pd;
    logic        e_ready, e_push, e_pop, ev, so, su, start, acc_c, acc_r;
    logic [63:0] e_data, ev_e, ev_a;

    rstn1 = 1'b0;
    rstn3 = 1'b0;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drv3(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    b1.i_full = 1'b0; b1.i_empty = 1'b0; b1.i_clear_viol = 1'b0; b1.i_pop_data = 64'd0;
    b3.i_full = 1'b0; b3.i_empty = 1'b0; b3.i_clear_viol = 1'b0; b3.i_pop_data = 64'd0;
    #12;
    chk("rst_ready",  64'(b1.o_commit_ready), 64'd1);
    chk("rst_viol",   64'(b1.o_violation), 64'd0);
    chk("rst_pulse",  64'(b1.o_viol_pulse), 64'd0);
    chk("rst_ovf",    64'(b1.o_overflow), 64'd0);
    chk("rst_udf",    64'(b1.o_underflow), 64'd0);
    chk("rst_ccnt",   64'(b1.o_call_cnt), 64'd0);
    chk("rst_rcnt",   64'(b1.o_ret_cnt), 64'd0);
    chk("rst_exp",    b1.o_viol_expected, 64'd0);
    chk("rst_act",    b1.o_viol_actual, 64'd0);
    chk("rst_push",   64'(b1.o_push), 64'd0);
    chk("rst_pop",    64'(b1.o_pop), 64'd0);
    @(negedge clk);
    rstn1 = 1'b1;
    rstn3 = 1'b1;

    // Plain 4-byte call
    @(negedge clk);
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'd0);
    #1;
    chk("call_push", 64'(b1.o_push), 64'd1);
    chk("call_data", b1.o_push_data, 64'h8000_0004);
    chk("call_pop",  64'(b1.o_pop), 64'd0);
    step();
    chk("call_cnt",  64'(b1.o_call_cnt), 64'd1);

    // Matching return, RD_LAT=1
    @(negedge clk);
    b1.i_pop_data = 64'h8000_0004;
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0100, 64'h8000_0004);
    #1;
    chk("ret_pop",   64'(b1.o_pop), 64'd1);
    chk("ret_push",  64'(b1.o_push), 64'd0);
    step();
    chk("ret_stall", 64'(b1.o_commit_ready), 64'd0);
    chk("ret_cnt",   64'(b1.o_ret_cnt), 64'd1);
    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("ret_ready", 64'(b1.o_commit_ready), 64'd1);
    chk("ret_noviol", 64'(b1.o_violation), 64'd0);
    chk("ret_nopulse", 64'(b1.o_viol_pulse), 64'd0);

    // Mismatching return
    @(negedge clk);
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_0100);
    #1;
    chk("mm_pop", 64'(b1.o_pop), 64'd1);
    step();
    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("mm_viol",  64'(b1.o_violation), 64'd1);
    chk("mm_pulse", 64'(b1.o_viol_pulse), 64'd1);
    chk("mm_exp",   b1.o_viol_expected, 64'h8000_0004);
    chk("mm_act",   b1.o_viol_actual, 64'h8000_0100);
    step();
    chk("mm_pulse_end", 64'(b1.o_viol_pulse), 64'd0);
    chk("mm_sticky",    64'(b1.o_violation), 64'd1);

    // Second mismatch keeps the first capture
    @(negedge clk);
    b1.i_pop_data = 64'h1111_0000;
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_0200);
    step();
    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("mm2_pulse", 64'(b1.o_viol_pulse), 64'd1);
    chk("mm2_exp",   b1.o_viol_expected, 64'h8000_0004);
    chk("mm2_act",   b1.o_viol_actual, 64'h8000_0100);
    chk("mm2_rcnt",  64'(b1.o_ret_cnt), 64'd3);

    // Compressed call into a full stack, then clear
    @(negedge clk);
    b1.i_full = 1'b1;
    drv1(1'b1, 1'b1, 1'b0, 1'b1, 64'h1002, 64'd0);
    #1;
    chk("ovf_nopush", 64'(b1.o_push), 64'd0);
    step();
    chk("ovf_flag", 64'(b1.o_overflow), 64'd1);
    chk("ovf_ccnt", 64'(b1.o_call_cnt), 64'd2);
    @(negedge clk);
    b1.i_full = 1'b0;
    b1.i_clear_viol = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("clr_ovf",  64'(b1.o_overflow), 64'd0);
    chk("clr_viol", 64'(b1.o_violation), 64'd0);

    // Compressed call with room, and a wrapping PC
    @(negedge clk);
    b1.i_clear_viol = 1'b0;
    drv1(1'b1, 1'b1, 1'b0, 1'b1, 64'h1002, 64'd0);
    #1;
    chk("cc_data", b1.o_push_data, 64'h1004);
    @(negedge clk);
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    #1;
    chk("wrap_push", 64'(b1.o_push), 64'd1);
    chk("wrap_data", b1.o_push_data, 64'h2);
    step();
    chk("wrap_ccnt", 64'(b1.o_call_cnt), 64'd4);

    // Return on an empty stack
    @(negedge clk);
    b1.i_empty = 1'b1;
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 64'hDEAD_0000);
    #1;
    chk("udf_nopop", 64'(b1.o_pop), 64'd0);
    step();
    chk("udf_ready", 64'(b1.o_commit_ready), 64'd1);
    chk("udf_flag",  64'(b1.o_underflow), 64'd1);
    chk("udf_viol",  64'(b1.o_violation), 64'd1);
    chk("udf_pulse", 64'(b1.o_viol_pulse), 64'd1);
    chk("udf_exp",   b1.o_viol_expected, 64'd0);
    chk("udf_act",   b1.o_viol_actual, 64'hDEAD_0000);

    // Clear coinciding with a new violation: set wins and capture reloads
    @(negedge clk);
    b1.i_clear_viol = 1'b1;
    drv1(1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 64'hBEEF_0000);
    step();
    chk("cs_viol", 64'(b1.o_violation), 64'd1);
    chk("cs_udf",  64'(b1.o_underflow), 64'd1);
    chk("cs_act",  b1.o_viol_actual, 64'hBEEF_0000);
    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("cs_clr_viol", 64'(b1.o_violation), 64'd0);
    chk("cs_clr_udf",  64'(b1.o_underflow), 64'd0);
    @(negedge clk);
    b1.i_clear_viol = 1'b0;
    b1.i_empty = 1'b0;

    // RD_LAT=3 coroutine swap: pop in cycle 0, deferred push in cycle 3
    @(negedge clk);
    b3.i_pop_data = 64'h2004;
    drv3(1'b1, 1'b1, 1'b1, 1'b0, 64'h2000, 64'h2004);
    #1;
    chk("sw_pop",  64'(b3.o_pop), 64'd1);
    chk("sw_push0", 64'(b3.o_push), 64'd0);
    step();
    chk("sw_stall1", 64'(b3.o_commit_ready), 64'd0);
    chk("sw_push1",  64'(b3.o_push), 64'd0);
    @(negedge clk);
    drv3(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("sw_stall2", 64'(b3.o_commit_ready), 64'd0);
    chk("sw_push2",  64'(b3.o_push), 64'd0);
    step();
    chk("sw_push3",  64'(b3.o_push), 64'd1);
    chk("sw_data3",  b3.o_push_data, 64'h2004);
    chk("sw_pop3",   64'(b3.o_pop), 64'd0);
    chk("sw_stall3", 64'(b3.o_commit_ready), 64'd0);
    step();
    chk("sw_ready4", 64'(b3.o_commit_ready), 64'd1);
    chk("sw_noviol", 64'(b3.o_violation), 64'd0);
    chk("sw_ccnt",   64'(b3.o_call_cnt), 64'd1);
    chk("sw_rcnt",   64'(b3.o_ret_cnt), 64'd1);

    // Same swap, reset pulsed while waiting for the read data
    @(negedge clk);
    drv3(1'b1, 1'b1, 1'b1, 1'b0, 64'h2000, 64'h2004);
    step();
    chk("rw_stall", 64'(b3.o_commit_ready), 64'd0);
    rstn3 = 1'b0;
    #1;
    chk("rw_ready", 64'(b3.o_commit_ready), 64'd1);
    chk("rw_push",  64'(b3.o_push), 64'd0);
    chk("rw_ccnt",  64'(b3.o_call_cnt), 64'd0);
    chk("rw_rcnt",  64'(b3.o_ret_cnt), 64'd0);
    chk("rw_viol",  64'(b3.o_violation), 64'd0);
    @(negedge clk);
    drv3(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    @(negedge clk);
    rstn3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_nopush", 64'(b3.o_push), 64'd0);
      chk("rw_nopulse", 64'(b3.o_viol_pulse), 64'd0);
    end

    // Randomized traffic on the RD_LAT=3 instance against the reference model
    m_busy = 0; m_tgt = '0; m_pc = '0; m_c = 1'b0; m_call = 1'b0;
    m_viol = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_pulse = 1'b0;
    m_exp = '0; m_act = '0; m_ccnt = 0; m_rcnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 9) < 7);
      ca = ($urandom_range(0, 4) < 2);
      re = ($urandom_range(0, 4) < 2);
      cp = ($urandom_range(0, 1) == 1);
      fu = ($urandom_range(0, 3) == 0);
      em = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 9) == 0);
      pc = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
      tg = ($urandom_range(0, 1) == 1) ? pc + 64'd8 : {$urandom, $urandom};
      pd = ((m_busy == 1) && ($urandom_range(0, 1) == 1)) ? m_tgt : {$urandom, $urandom};
      drv3(v, ca, re, cp, pc, tg);
      b3.i_full = fu; b3.i_empty = em; b3.i_clear_viol = cl; b3.i_pop_data = pd;
      #1;

      e_ready = (m_busy == 0);
      e_push = 1'b0; e_pop = 1'b0; e_data = '0;
      ev = 1'b0; ev_e = '0; ev_a = '0; so = 1'b0; su = 1'b0;
      start = 1'b0; acc_c = 1'b0; acc_r = 1'b0;
      if (m_busy == 0) begin
        if (v) begin
          acc_c = ca;
          acc_r = re;
          if (re && !em) begin
            e_pop = 1'b1;
            start = 1'b1;
          end else begin
            if (re) begin
              su = 1'b1; ev = 1'b1; ev_e = 64'd0; ev_a = tg;
            end
            if (ca && fu) so = 1'b1;
            if (ca && !fu) begin
              e_push = 1'b1;
              e_data = pc + (cp ? 64'd2 : 64'd4);
            end
          end
        end
      end else if (m_busy == 1) begin
        if (pd !== m_tgt) begin
          ev = 1'b1; ev_e = pd; ev_a = m_tgt;
        end
        if (m_call && fu) so = 1'b1;
        if (m_call && !fu) begin
          e_push = 1'b1;
          e_data = m_pc + (m_c ? 64'd2 : 64'd4);
        end
      end
      chk("rnd_ready", 64'(b3.o_commit_ready), 64'(e_ready));
      chk("rnd_push",  64'(b3.o_push), 64'(e_push));
      chk("rnd_pop",   64'(b3.o_pop), 64'(e_pop));
      if (e_push) chk("rnd_pdata", b3.o_push_data, e_data);

      step();
      if (start) begin
        m_busy = L3; m_tgt = tg; m_pc = pc; m_c = cp; m_call = ca;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      m_pulse = ev;
      if (ev && (!m_viol || cl)) begin
        m_exp = ev_e;
        m_act = ev_a;
      end
      if (ev) m_viol = 1'b1; else if (cl) m_viol = 1'b0;
      if (so) m_ovf  = 1'b1; else if (cl) m_ovf  = 1'b0;
      if (su) m_udf  = 1'b1; else if (cl) m_udf  = 1'b0;
      if (acc_c && m_ccnt < CMAX3) m_ccnt++;
      if (acc_r && m_rcnt < CMAX3) m_rcnt++;
      chk("rnd_viol",  64'(b3.o_violation), 64'(m_viol));
      chk("rnd_pulse", 64'(b3.o_viol_pulse), 64'(m_pulse));
      chk("rnd_exp",   b3.o_viol_expected, m_exp);
      chk("rnd_act",   b3.o_viol_actual, m_act);
      chk("rnd_ovf",   64'(b3.o_overflow), 64'(m_ovf));
      chk("rnd_udf",   64'(b3.o_underflow), 64'(m_udf));
      chk("rnd_ccnt",  64'(b3.o_call_cnt), 64'(m_ccnt));
      chk("rnd_rcnt",  64'(b3.o_ret_cnt), 64'(m_rcnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
